// File: rtl/entrada_bcd_pkg.sv
// Shared types and constants for the two-digit BCD entry block.
package entrada_bcd_pkg;

   // Operator prompt states; the code 11 is never entered.
   typedef enum logic [1:0] {
      ESPERA_DEZ = 2'b00,
      ESPERA_UNI = 2'b01,
      PRONTO     = 2'b10
   } estado_t;

   localparam int DIG_MAX = 9;
   localparam int VAL_W   = 7;

   // tens*10 + units using shifts; 9*10+9 = 99 fits in VAL_W bits.
   function automatic logic [VAL_W-1:0] bcd_valor(input logic [3:0] dez,
                                                  input logic [3:0] uni);
      logic [VAL_W-1:0] d;
      d = VAL_W'(dez);
      return (d << 3) + (d << 1) + VAL_W'(uni);
   endfunction

endpackage

// File: rtl/entrada_bcd_sinc_botao.sv
// Button synchroniser and rising-edge detector producing a one-cycle press.
module sinc_botao #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   edge_q;

   // Chain and edge register preset to 1 so a button held through reset is not a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= '1;
         edge_q <= 1'b1;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], btn};
         edge_q <= sync[SYNC_STAGES-1];
      end
   end

   assign press = sync[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/entrada_bcd.sv
// Two-digit BCD entry: validates digits, assembles tens*10+units, hands off via valido/aceito.
module entrada_bcd
   import entrada_bcd_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       sw,
   input  logic             btn,
   input  logic             clr,
   input  logic             aceito,
   output logic [VAL_W-1:0] valor,
   output logic             valido,
   output logic             erro,
   output logic [1:0]       estado
);

   estado_t    state;
   estado_t    next_state;
   logic       press;
   logic       dig_ok;
   logic [3:0] tens;
   logic       load_dez;
   logic       load_val;
   logic       set_erro;
   logic       accept;

   sinc_botao #(.SYNC_STAGES(SYNC_STAGES)) u_sinc (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .press (press)
   );

   assign dig_ok = (sw <= 4'(DIG_MAX));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ESPERA_DEZ;
      else        state <= next_state;
   end

   // Next-state and datapath strobes; clr overrides any press or accept.
   always_comb begin
      next_state = state;
      load_dez   = 1'b0;
      load_val   = 1'b0;
      set_erro   = 1'b0;
      accept     = 1'b0;
      if (clr) begin
         next_state = ESPERA_DEZ;
      end else begin
         case (state)
            ESPERA_DEZ: begin
               if (press) begin
                  if (dig_ok) begin
                     load_dez   = 1'b1;
                     next_state = ESPERA_UNI;
                  end else begin
                     set_erro = 1'b1;
                  end
               end
            end
            ESPERA_UNI: begin
               if (press) begin
                  if (dig_ok) begin
                     load_val   = 1'b1;
                     next_state = PRONTO;
                  end else begin
                     set_erro = 1'b1;
                  end
               end
            end
            PRONTO: begin
               // Presses here are dropped, including one coinciding with the accept edge.
               if (valido && aceito) begin
                  accept     = 1'b1;
                  next_state = ESPERA_DEZ;
               end
            end
            default: next_state = ESPERA_DEZ;
         endcase
      end
   end

   // Tens digit and registered outputs; valor keeps its value across an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens   <= '0;
         valor  <= '0;
         valido <= 1'b0;
         erro   <= 1'b0;
      end else if (clr) begin
         tens   <= '0;
         valor  <= '0;
         valido <= 1'b0;
         erro   <= 1'b0;
      end else begin
         if (load_dez) begin
            tens <= sw;
            erro <= 1'b0;
         end
         if (load_val) begin
            valor  <= bcd_valor(tens, sw);
            valido <= 1'b1;
            erro   <= 1'b0;
         end
         if (set_erro) erro <= 1'b1;
         if (accept) valido <= 1'b0;
      end
   end

   // Operator prompt is the raw state code.
   always_comb begin
      estado = state;
   end

endmodule

// File: tb/tb_entrada_bcd.sv
// Self-checking bench for entrada_bcd: directed scenarios plus randomized entry against a model.
module tb_entrada_bcd;

   localparam int S = 2;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic [3:0] sw     = 4'd0;
   logic       btn    = 1'b0;
   logic       clr    = 1'b0;
   logic       aceito = 1'b0;
   logic [6:0] valor;
   logic       valido;
   logic       erro;
   logic [1:0] estado;

   int checks = 0;
   int errors = 0;

   // Reference model: an entry in progress as digit phase (0 tens, 1 units, 2 ready).
   int m_phase;
   int m_tens;
   int m_valor;
   bit m_valido;
   bit m_erro;

   entrada_bcd #(.SYNC_STAGES(S)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw     (sw),
      .btn    (btn),
      .clr    (clr),
      .aceito (aceito),
      .valor  (valor),
      .valido (valido),
      .erro   (erro),
      .estado (estado)
   );

   always #5 clk = ~clk;

   function automatic string show(input logic [10:0] v);
      return $sformatf("valor=%0d valido=%0b erro=%0b estado=%b", v[10:4], v[3], v[2], v[1:0]);
   endfunction

   function automatic logic [10:0] got();
      return {valor, valido, erro, estado};
   endfunction

   function automatic logic [10:0] model_vec();
      return {7'(m_valor), m_valido, m_erro, 2'(m_phase)};
   endfunction

   function automatic void m_clear();
      m_phase = 0; m_tens = 0; m_valor = 0; m_valido = 0; m_erro = 0;
   endfunction

   function automatic void m_press(input int d);
      if (m_phase == 0) begin
         if (d <= 9) begin m_tens = d; m_erro = 0; m_phase = 1; end
         else m_erro = 1;
      end else if (m_phase == 1) begin
         if (d <= 9) begin m_valor = m_tens * 10 + d; m_valido = 1; m_erro = 0; m_phase = 2; end
         else m_erro = 1;
      end
   endfunction

   function automatic void m_accept();
      if (m_valido) begin m_valido = 0; m_phase = 0; end
   endfunction

   task automatic press(input logic [3:0] d);
      @(negedge clk);
      sw  = d;
      btn = 1'b1;
      repeat (S + 2) @(negedge clk);
      btn = 1'b0;
      sw  = 4'($urandom);
      repeat (S + 2) @(negedge clk);
   endtask

   task automatic pulse_aceito();
      @(negedge clk);
      aceito = 1'b1;
      @(negedge clk);
      aceito = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (got() !== 11'd0) begin
         errors++; $display("FAIL reset_values got %s need %s", show(got()), show(11'd0));
      end
      #12 rst_n = 1'b1;
      repeat (S + 3) @(negedge clk);
      checks++;
      if (got() !== 11'd0) begin
         errors++; $display("FAIL after_release got %s need %s", show(got()), show(11'd0));
      end
   endtask

   task automatic test_normal();
      logic [10:0] e;
      @(negedge clk);
      sw = 4'd4; btn = 1'b1;
      repeat (S) @(negedge clk);
      checks++;
      if (estado !== 2'b00) begin
         errors++; $display("FAIL latency_early estado got %b need 00", estado);
      end
      @(negedge clk);
      checks++;
      if (estado !== 2'b01) begin
         errors++; $display("FAIL latency_tens estado got %b need 01", estado);
      end
      repeat (S) @(negedge clk);
      btn = 1'b0;
      repeat (S + 2) @(negedge clk);
      press(4'd7);
      e = {7'd47, 1'b1, 1'b0, 2'b10};
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (got() !== e) begin
            errors++; $display("FAIL normal_hold_%0d got %s need %s", i, show(got()), show(e));
         end
         @(negedge clk);
      end
      pulse_aceito();
      e = {7'd47, 1'b0, 1'b0, 2'b00};
      checks++;
      if (got() !== e) begin
         errors++; $display("FAIL normal_accept got %s need %s", show(got()), show(e));
      end
   endtask

   task automatic test_invalid();
      logic [10:0] e;
      press(4'd12);
      e = {7'd47, 1'b0, 1'b1, 2'b00};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL invalid_tens got %s need %s", show(got()), show(e)); end
      press(4'd3);
      e = {7'd47, 1'b0, 1'b0, 2'b01};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL valid_after_err got %s need %s", show(got()), show(e)); end
      press(4'd0);
      e = {7'd30, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL value_30 got %s need %s", show(got()), show(e)); end
      pulse_aceito();
      press(4'd3);
      press(4'd15);
      e = {7'd30, 1'b0, 1'b1, 2'b01};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL invalid_units got %s need %s", show(got()), show(e)); end
      press(4'd4);
      e = {7'd34, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL tens_retained got %s need %s", show(got()), show(e)); end
      pulse_aceito();
   endtask

   task automatic test_extremes();
      logic [10:0] e;
      press(4'd9);
      press(4'd9);
      e = {7'd99, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL value_99 got %s need %s", show(got()), show(e)); end
      pulse_aceito();
      press(4'd0);
      press(4'd0);
      e = {7'd0, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL value_00 got %s need %s", show(got()), show(e)); end
      pulse_aceito();
   endtask

   task automatic test_lockout();
      logic [10:0] e;
      press(4'd2);
      press(4'd5);
      press(4'd5);
      press(4'd5);
      e = {7'd25, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL pronto_lockout got %s need %s", show(got()), show(e)); end
      @(negedge clk);
      sw = 4'd6; btn = 1'b1;
      repeat (S) @(negedge clk);
      aceito = 1'b1;
      @(negedge clk);
      aceito = 1'b0;
      repeat (S) @(negedge clk);
      btn = 1'b0;
      repeat (S + 2) @(negedge clk);
      e = {7'd25, 1'b0, 1'b0, 2'b00};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL press_at_accept got %s need %s", show(got()), show(e)); end
      press(4'd8);
      press(4'd1);
      e = {7'd81, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL after_lockout got %s need %s", show(got()), show(e)); end
      pulse_aceito();
   endtask

   task automatic test_reset_mid();
      logic [10:0] e;
      press(4'd6);
      e = {7'd81, 1'b0, 1'b0, 2'b01};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL mid_tens got %s need %s", show(got()), show(e)); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (got() !== 11'd0) begin errors++; $display("FAIL async_reset got %s need %s", show(got()), show(11'd0)); end
      btn = 1'b1;
      sw  = 4'd5;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (S + 4) @(negedge clk);
      checks++;
      if (got() !== 11'd0) begin errors++; $display("FAIL held_btn got %s need %s", show(got()), show(11'd0)); end
      btn = 1'b0;
      repeat (S + 2) @(negedge clk);
      press(4'd5);
      press(4'd2);
      e = {7'd52, 1'b1, 1'b0, 2'b10};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL after_reset_entry got %s need %s", show(got()), show(e)); end
      pulse_aceito();
   endtask

   task automatic test_clr();
      logic [10:0] e;
      press(4'd7);
      @(negedge clk);
      sw = 4'd3; btn = 1'b1;
      repeat (S) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (S) @(negedge clk);
      btn = 1'b0;
      repeat (S + 2) @(negedge clk);
      e = {7'd0, 1'b0, 1'b0, 2'b00};
      checks++;
      if (got() !== e) begin errors++; $display("FAIL clr_priority got %s need %s", show(got()), show(e)); end
   endtask

   task automatic test_random();
      int r;
      int d;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_clear();
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            d = $urandom_range(0, 15);
            press(4'(d));
            m_press(d);
         end else if (r < 8) begin
            pulse_aceito();
            m_accept();
         end else begin
            @(negedge clk);
            clr    = 1'b1;
            aceito = (r == 9);
            @(negedge clk);
            clr    = 1'b0;
            aceito = 1'b0;
            m_clear();
         end
         checks++;
         if (got() !== model_vec()) begin
            errors++; $display("FAIL random_%0d got %s need %s", i, show(got()), show(model_vec()));
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_invalid();
      test_extremes();
      test_lockout();
      test_reset_mid();
      test_clr();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
